shift_seq_ctrl: RTL

Command sequencer that sits directly upstream of the 8-bit universal shift register (`eightBit`) and drives its `select`, `pload`, `lftin` and `rghtin` inputs. Each accepted command is either a parallel load or a shift of N positions with a chosen serial fill bit. On completion the block reads the register's `out` back into `result` and pulses `done`. It replaces hand-sequenced `select` stimulus with a valid/ready command interface.

---
 rtl/shift_seq_ctrl.sv | 102 ++++++++++
 1 files changed

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: valid/ready command sequencer driving an 8-bit universal shift register
module shift_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNTW  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             cmd_fill,
    input  logic [CNTW-1:0]  cmd_cnt,
    input  logic [WIDTH-1:0] usr_out,
    output logic [1:0]       select,
    output logic [WIDTH-1:0] pload,
    output logic             lftin,
    output logic             rghtin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, CAPTURE} state_t;
    state_t           state_q, state_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [1:0]       op_q, op_d, select_q, select_d;
    logic             fill_q, fill_d, lftin_q, lftin_d, rghtin_q, rghtin_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic [WIDTH-1:0] pload_q, pload_d, result_q, result_d;
    logic             accept;
    assign cmd_ready = rst_n && state_q == IDLE;
    assign accept    = cmd_valid && cmd_ready;
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pload_d  = pload_q;
        op_d     = accept ? cmd_op : op_q;
        fill_d   = accept ? cmd_fill : fill_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (cmd_op == 2'b11) begin
                        state_d = LOAD;
                        pload_d = cmd_data;
                    end else if (cmd_op != 2'b00 && cmd_cnt != '0) begin
                        state_d = SHIFT;
                        cnt_d   = cmd_cnt;
                    end else begin
                        state_d = CAPTURE;
                    end
                end
            end
            LOAD:  state_d = CAPTURE;
            SHIFT: begin
                cnt_d = cnt_q - CNTW'(1);
                if (cnt_q == CNTW'(1)) state_d = CAPTURE;
            end
            default: state_d = IDLE;
        endcase
        // Outputs are registered, so they are decoded from the state being entered
        select_d = state_d == LOAD ? 2'b11 : state_d == SHIFT ? op_d : 2'b00;
        lftin_d  = state_d == SHIFT && op_d == 2'b10 && fill_d;
        rghtin_d = state_d == SHIFT && op_d == 2'b01 && fill_d;
        busy_d   = state_d != IDLE;
        done_d   = state_q == CAPTURE;
        result_d = state_q == CAPTURE ? usr_out : result_q;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            fill_q   <= 1'b0;
            select_q <= '0;
            pload_q  <= '0;
            lftin_q  <= 1'b0;
            rghtin_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            fill_q   <= fill_d;
            select_q <= select_d;
            pload_q  <= pload_d;
            lftin_q  <= lftin_d;
            rghtin_q <= rghtin_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end
    assign select = select_q;
    assign pload  = pload_q;
    assign lftin  = lftin_q;
    assign rghtin = rghtin_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
endmodule
